// File: rtl/muldiv_controller.sv
// Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
// It runs a shift-add multiply or a restoring divide at one step per cycle, then uses
// one adjust cycle for sign correction and HI/LO writeback.
module muldiv_controller #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             md_stall
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_ADJUST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
    logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;  // raw dividend kept for divide-by-zero HI
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 idle;
    logic                 go;
    logic                 mt_en;
    logic                 sgn_in;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_mag;
    logic [WIDTH-1:0]     rem_mag;

    assign idle     = (state_q == S_IDLE);
    assign go       = start & ~flush & idle;
    // start has priority over mt_* in the same cycle
    assign mt_en    = ~start & ~flush & idle;
    assign busy     = ~idle;
    assign md_stall = busy & (start | mf_req | mt_hi | mt_lo);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state, iteration datapath and HI/LO writeback selection
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        sgn_in = ~op[0];
        a_mag  = (sgn_in && a[WIDTH-1]) ? -a : a;
        b_mag  = (sgn_in && b[WIDTH-1]) ? -b : b;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb_q};
        if (!div_trial[WIDTH+1]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        quo_mag = acc_q[WIDTH-1:0];
        rem_mag = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    a_raw_d   = a;
                    is_div_d  = op[1];
                    dz_d      = op[1] & (b == '0);
                    neg_quo_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn_in & a[WIDTH-1];
                    count_d   = '0;
                    state_d   = S_RUN;
                end else if (mt_en) begin
                    if (mt_hi) hi_d = a;
                    if (mt_lo) lo_d = a;
                end
            end
            S_RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    state_d = S_ADJUST;
                end
            end
            S_ADJUST: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_quo_q ? -acc_q : acc_q;
                end else if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else begin
                    lo_d = neg_quo_q ? -quo_mag : quo_mag;
                    hi_d = neg_rem_q ? -rem_mag : rem_mag;
                end
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and architectural registers; asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: expected HI/LO pushed at issue, popped when busy falls.
module tb_muldiv_controller;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  op     = 2'd0;
    logic        flush  = 1'b0;
    logic [31:0] a      = '0;
    logic [31:0] b      = '0;
    logic        mf_req = 1'b0;
    logic        mt_hi  = 1'b0;
    logic        mt_lo  = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    muldiv_controller #(.WIDTH(32), .STEPS(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .mf_req   (mf_req),
        .mt_hi    (mt_hi),
        .mt_lo    (mt_lo),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
    endtask

    // Monitor: a result is presented when busy falls; also measures busy length
    int busy_len  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hi=%h lo=%h expected none", hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    check32("result_hi", hi, e.hi);
                    check32("result_lo", lo, e.lo);
                    check32("busy_cycles", busy_len, 33);
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit expect_result);
        @(posedge clock); #1;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (expect_result) push_exp(ehi, elo);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
    endtask

    logic [1:0]  v_op [9] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] v_a  [9] = '{32'h7, 32'h7, 32'd100, 32'hFFFFFFF9, 32'h1234,
                              32'h80000000, 32'h80000005, 32'h7, 32'hFFFFFFFF};
    logic [31:0] v_b  [9] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd7, 32'd2, 32'h0,
                              32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] v_hi [9] = '{32'hFFFFFFFF, 32'h6, 32'd2, 32'hFFFFFFFF, 32'h1234,
                              32'h0, 32'h80000005, 32'h1, 32'h0};
    logic [31:0] v_lo [9] = '{32'hFFFFFFEB, 32'hFFFFFFEB, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1};

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        check32("reset_busy", busy, 32'h0);
        check32("reset_md_stall", md_stall, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Directed arithmetic vectors
        for (int i = 0; i < 9; i++) begin
            issue(v_op[i], v_a[i], v_b[i], v_hi[i], v_lo[i], 1'b1);
            wait_idle();
        end

        // Stall behaviour: MULT, mf_req from cycle 2, second start from cycle 10
        @(posedge clock); #1;
        start = 1'b1; op = 2'd0; a = 32'h10000; b = 32'h10000;
        push_exp(32'h1, 32'h0);
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 2; k <= 34; k++) begin
            @(posedge clock); #1;
            if (k == 2) mf_req = 1'b1;
            if (k == 10) begin
                start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd5;
                push_exp(32'h0, 32'd10);
            end
            @(negedge clock);
            check32("stall_md_stall", md_stall, (k <= 33) ? 32'h1 : 32'h0);
            check32("stall_busy", busy, (k <= 33) ? 32'h1 : 32'h0);
        end
        @(posedge clock); #1;
        start  = 1'b0;
        mf_req = 1'b0;
        check32("stalled_start_accepted", busy, 32'h1);
        wait_idle();

        // Asynchronous reset during RUN at count 10 aborts without writeback
        issue(2'd0, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
        repeat (10) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check32("abort_busy", busy, 32'h0);
        check32("abort_hi", hi, 32'h0);
        check32("abort_lo", lo, 32'h0);
        @(posedge clock); #3;
        reset = 1'b1;
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        wait_idle();

        // MTLO / MTHI in IDLE
        @(posedge clock); #1;
        mt_lo = 1'b1; a = 32'hDEADBEEF;
        @(posedge clock); #1;
        mt_lo = 1'b0;
        check32("mtlo_lo", lo, 32'hDEADBEEF);
        mt_hi = 1'b1; a = 32'h0BADF00D;
        @(posedge clock); #1;
        mt_hi = 1'b0;
        check32("mthi_hi", hi, 32'h0BADF00D);
        check32("mthi_lo_kept", lo, 32'hDEADBEEF);

        // Flushed MTHI and flushed start are ignored
        mt_hi = 1'b1; flush = 1'b1; a = 32'h11111111;
        @(posedge clock); #1;
        mt_hi = 1'b0; flush = 1'b0;
        check32("flush_mthi_hi", hi, 32'h0BADF00D);
        start = 1'b1; flush = 1'b1; op = 2'd3; a = 32'd9; b = 32'd4;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check32("flush_start_busy", busy, 32'h0);
        check32("flush_start_lo", lo, 32'hDEADBEEF);

        // start and MTHI together: op wins, HI only written by its result
        start = 1'b1; mt_hi = 1'b1; op = 2'd3; a = 32'd9; b = 32'd4;
        push_exp(32'd1, 32'd2);
        @(posedge clock); #1;
        start = 1'b0; mt_hi = 1'b0;
        check32("start_mt_busy", busy, 32'h1);
        check32("start_mt_hi_held", hi, 32'h0BADF00D);
        wait_idle();

        @(negedge clock);
        check32("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
